// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and the ALU decoder:
// FSM encodings, special opcodes and instruction-word field positions.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } seq_state_t;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_NOP  = 4'hE;

  localparam int IR_W      = 16;
  localparam int OP_LSB    = 12;
  localparam int WADDR_LSB = 8;
  localparam int RADDRA_LSB = 4;
  localparam int RADDRB_LSB = 0;

  function automatic logic [3:0] ir_field(input logic [IR_W-1:0] ir, input int lsb);
    return ir[lsb +: 4];
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory, register-file control and host handshake bundle.
interface program_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic              Stop;
  logic [ADDR_W-1:0] InstrAddr;
  logic [15:0]       InstrData;
  logic [3:0]        RAddrA;
  logic [3:0]        RAddrB;
  logic [3:0]        WAddr;
  logic [3:0]        AluOp;
  logic              Wen;
  logic              Ready;
  logic [CNT_W-1:0]  Retired;

  modport master (
    input  Start, Stop, InstrData,
    output InstrAddr, RAddrA, RAddrB, WAddr, AluOp, Wen, Ready, Retired
  );

  modport slave (
    output Start, Stop, InstrData,
    input  InstrAddr, RAddrA, RAddrB, WAddr, AluOp, Wen, Ready, Retired
  );
endinterface

// File: rtl/program_sequencer_sat_counter.sv
// Width-parameterised up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/program_sequencer.sv
// Multi-cycle instruction sequencer: fetch from a synchronous ROM, decode,
// drive register-file addresses and pulse the write enable once per ALU op.
//
// state  | meaning
// IDLE   | halted, Ready=1, waiting for Start
// FETCH  | InstrAddr=PC presented to ROM
// DECODE | ROM word latched into IR; HALT/NOP resolved here
// READ   | register-file read addresses valid
// EXEC   | ALU operating
// WB     | Wen=1 for one cycle, PC and Retired advance
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic CLK,
  input  logic RST,
  program_sequencer_if.master bus
);
  seq_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [IR_W-1:0]   r_ir, w_ir_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_wen, r_ready;
  logic              w_stop, w_cnt_clr, w_cnt_inc;
  logic [3:0]        w_op;
  logic [CNT_W-1:0]  w_retired;

  assign w_stop = r_pend | bus.Stop;
  assign w_op   = ir_field(bus.InstrData, OP_LSB);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_pend_nxt  = (r_state == S_IDLE) ? 1'b0 : w_stop;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_cnt_clr   = 1'b1;
          w_pend_nxt  = bus.Stop;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_ir_nxt = bus.InstrData;
        if (w_op == OP_HALT) begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end else if (w_op == OP_NOP) begin
          w_pc_nxt = r_pc + ADDR_W'(1);
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = S_WB;
      S_WB: begin
        w_pc_nxt  = r_pc + ADDR_W'(1);
        w_cnt_inc = 1'b1;
        if (w_stop) begin
          w_state_nxt = S_IDLE;
          w_pend_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Wen/Ready are registered from the next state so they line up with r_state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_pend  <= 1'b0;
      r_wen   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_pend  <= w_pend_nxt;
      r_wen   <= (w_state_nxt == S_WB);
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  sat_counter #(.W(CNT_W)) u_retired (
    .CLK   (CLK),
    .RST   (RST),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_cnt (w_retired)
  );

  assign bus.InstrAddr = r_pc;
  assign bus.AluOp     = ir_field(r_ir, OP_LSB);
  assign bus.WAddr     = ir_field(r_ir, WADDR_LSB);
  assign bus.RAddrA    = ir_field(r_ir, RADDRA_LSB);
  assign bus.RAddrB    = ir_field(r_ir, RADDRB_LSB);
  assign bus.Wen       = r_wen;
  assign bus.Ready     = r_ready;
  assign bus.Retired   = w_retired;
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: expected write-backs are queued at stimulus time and
// popped by a monitor on every Wen pulse; direct checks cover status outputs.
module tb_program_sequencer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  program_sequencer_if #(.ADDR_W(8), .CNT_W(16)) bus_a ();
  program_sequencer_if #(.ADDR_W(2), .CNT_W(3))  bus_b ();

  program_sequencer #(.ADDR_W(8), .CNT_W(16)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  program_sequencer #(.ADDR_W(2), .CNT_W(3))  dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [4];

  always @(posedge CLK) begin
    bus_a.InstrData <= rom_a[bus_a.InstrAddr];
    bus_b.InstrData <= rom_b[bus_b.InstrAddr];
  end

  typedef struct {
    logic [3:0] waddr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] op;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  task automatic push_exp(input bit sel_b, input logic [15:0] instr, input int c);
    exp_t e;
    e.waddr = instr[11:8];
    e.ra    = instr[7:4];
    e.rb    = instr[3:0];
    e.op    = instr[15:12];
    e.cyc   = c;
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (bus_a.Wen) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL wb_a unexpected Wen at cyc %0d", cyc);
      end else begin
        e_a = q_a.pop_front();
        if (bus_a.WAddr != e_a.waddr || bus_a.RAddrA != e_a.ra || bus_a.RAddrB != e_a.rb ||
            bus_a.AluOp != e_a.op || cyc != e_a.cyc) begin
          errors++;
          $display("FAIL wb_a got w%0h a%0h b%0h op%0h cyc%0d expected w%0h a%0h b%0h op%0h cyc%0d",
                   bus_a.WAddr, bus_a.RAddrA, bus_a.RAddrB, bus_a.AluOp, cyc,
                   e_a.waddr, e_a.ra, e_a.rb, e_a.op, e_a.cyc);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (bus_b.Wen) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL wb_b unexpected Wen at cyc %0d", cyc);
      end else begin
        e_b = q_b.pop_front();
        if (bus_b.WAddr != e_b.waddr || bus_b.RAddrA != e_b.ra || bus_b.RAddrB != e_b.rb ||
            bus_b.AluOp != e_b.op || cyc != e_b.cyc) begin
          errors++;
          $display("FAIL wb_b got w%0h a%0h b%0h op%0h cyc%0d expected w%0h a%0h b%0h op%0h cyc%0d",
                   bus_b.WAddr, bus_b.RAddrA, bus_b.RAddrB, bus_b.AluOp, cyc,
                   e_b.waddr, e_b.ra, e_b.rb, e_b.op, e_b.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_a(input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3);
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hF000;
    rom_a[0] = p0; rom_a[1] = p1; rom_a[2] = p2; rom_a[3] = p3;
  endtask

  // Start (optionally with Stop) sampled at one edge; returns the cycle stamp of that edge.
  task automatic start_a(input logic with_stop, output int s);
    bus_a.Start = 1'b1;
    bus_a.Stop  = with_stop;
    @(negedge CLK);
    bus_a.Start = 1'b0;
    bus_a.Stop  = 1'b0;
    s = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    bus_a.Start = 1'b0; bus_a.Stop = 1'b0;
    bus_b.Start = 1'b0; bus_b.Stop = 1'b0;
    load_a(16'hF000, 16'hF000, 16'hF000, 16'hF000);
    rom_b[0] = 16'h1321; rom_b[1] = 16'h2432; rom_b[2] = 16'h3543; rom_b[3] = 16'h4654;

    // reset state
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
    chk("rst_ready", 32'(bus_a.Ready), 32'd1);
    chk("rst_wen", 32'(bus_a.Wen), 32'd0);
    chk("rst_addr", 32'(bus_a.InstrAddr), 32'd0);
    chk("rst_retired", 32'(bus_a.Retired), 32'd0);

    // single ALU op then HALT
    load_a(16'h1321, 16'hF000, 16'hF000, 16'hF000);
    start_a(1'b0, s);
    push_exp(1'b0, 16'h1321, s + 4);
    chk("p1_busy", 32'(bus_a.Ready), 32'd0);
    step(6);
    chk("p1_halt_decode", 32'(bus_a.Ready), 32'd0);
    step(1);
    chk("p1_ready", 32'(bus_a.Ready), 32'd1);
    chk("p1_retired", 32'(bus_a.Retired), 32'd1);
    step(2);

    // two NOPs, an ALU op, HALT
    load_a(16'hE000, 16'hE000, 16'h2456, 16'hF000);
    start_a(1'b0, s);
    push_exp(1'b0, 16'h2456, s + 8);
    step(11);
    chk("p2_ready", 32'(bus_a.Ready), 32'd1);
    chk("p2_retired", 32'(bus_a.Retired), 32'd1);
    step(2);

    // stop during EXEC of instruction 2
    load_a(16'h1123, 16'h2234, 16'h3345, 16'h4456);
    start_a(1'b0, s);
    push_exp(1'b0, 16'h1123, s + 4);
    push_exp(1'b0, 16'h2234, s + 9);
    step(8);
    bus_a.Stop = 1'b1;
    step(1);
    bus_a.Stop = 1'b0;
    chk("p3_wb_not_ready", 32'(bus_a.Ready), 32'd0);
    step(1);
    chk("p3_ready", 32'(bus_a.Ready), 32'd1);
    chk("p3_retired", 32'(bus_a.Retired), 32'd2);
    step(6);
    chk("p3_still_idle", 32'(bus_a.Ready), 32'd1);
    chk("p3_no_fetch", 32'(bus_a.InstrAddr), 32'd2);

    // Start and Stop together, first instruction a NOP
    load_a(16'hE000, 16'h1321, 16'h2456, 16'hF000);
    start_a(1'b1, s);
    step(1);
    chk("p4_decode_busy", 32'(bus_a.Ready), 32'd0);
    step(1);
    chk("p4_ready", 32'(bus_a.Ready), 32'd1);
    chk("p4_retired", 32'(bus_a.Retired), 32'd0);
    step(3);
    chk("p4_still_idle", 32'(bus_a.Ready), 32'd1);

    // mid-run Start ignored, then reset during WB
    load_a(16'h1321, 16'h2456, 16'hF000, 16'hF000);
    start_a(1'b0, s);
    push_exp(1'b0, 16'h1321, s + 4);
    push_exp(1'b0, 16'h2456, s + 9);
    step(6);
    bus_a.Start = 1'b1;
    step(1);
    bus_a.Start = 1'b0;
    step(2);
    chk("p5_wb_wen", 32'(bus_a.Wen), 32'd1);
    chk("p5_pc_kept", 32'(bus_a.InstrAddr), 32'd1);
    chk("p5_retired_kept", 32'(bus_a.Retired), 32'd1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("p5_rst_wen", 32'(bus_a.Wen), 32'd0);
    chk("p5_rst_ready", 32'(bus_a.Ready), 32'd1);
    chk("p5_rst_addr", 32'(bus_a.InstrAddr), 32'd0);
    chk("p5_rst_retired", 32'(bus_a.Retired), 32'd0);
    step(3);
    chk("p5_idle_after", 32'(bus_a.Ready), 32'd1);

    // narrow instance: PC wrap and counter saturation
    bus_b.Start = 1'b1;
    step(1);
    bus_b.Start = 1'b0;
    s = cyc;
    for (int k = 0; k < 10; k++) push_exp(1'b1, rom_b[k % 4], s + 5 * k + 4);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(5);
      chk($sformatf("b_fetch%0d", k), 32'(bus_b.InstrAddr), 32'(k % 4));
    end
    step(4);
    chk("b_retired24", 32'(bus_b.Retired), 32'd4);
    step(1);
    chk("b_retired25", 32'(bus_b.Retired), 32'd5);
    step(5);
    chk("b_retired30", 32'(bus_b.Retired), 32'd6);
    step(15);
    chk("b_saturated", 32'(bus_b.Retired), 32'd7);
    bus_b.Stop = 1'b1;
    step(1);
    bus_b.Stop = 1'b0;
    step(4);
    chk("b_ready", 32'(bus_b.Ready), 32'd1);
    chk("b_sat_hold", 32'(bus_b.Retired), 32'd7);
    step(4);

    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
